alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//  Shares a single combinational ALU_4bit instance between NUM_REQ requesters.
//  Round-robin arbitration picks one request at a time. Operands and op are registered and
//  driven to the ALU for one cycle. Result and zero flag are captured and returned to the
//  granted requester with a valid/ready handshake. The block sits between the requesters
//  and the ALU; the ALU itself is instantiated outside and connected through the alu_* ports.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8); ID_W = $clog2(NUM_REQ), minimum 1
//  DATA_W   4  operand/result width; must match the ALU width
//  OP_W     3  ALUControl width; the value is passed through opaquely
// PORTS
//  clk         in   1               rising-edge clock
//  rst_n       in   1               asynchronous active-low reset
//  req_valid   in   NUM_REQ         per-requester request valid
//  req_ready   out  NUM_REQ         per-requester accept (one-hot or zero)
//  req_a       in   NUM_REQ*DATA_W  operand A; requester i uses bits [i*DATA_W +: DATA_W]
//  req_b       in   NUM_REQ*DATA_W  operand B, packed the same way
//  req_op      in   NUM_REQ*OP_W    ALUControl code; requester i uses bits [i*OP_W +: OP_W]
//  alu_a       out  DATA_W          to ALU A
//  alu_b       out  DATA_W          to ALU B
//  alu_ctrl    out  OP_W            to ALU ALUControl
//  alu_result  in   DATA_W          from ALU result
//  alu_zero    in   1               from ALU zero
//  rsp_valid   out  NUM_REQ         one-hot response valid, addressed to the granted requester
//  rsp_ready   in   NUM_REQ         per-requester response accept
//  rsp_result  out  DATA_W          captured ALU result
//  rsp_zero    out  1               captured ALU zero flag
//  rsp_id      out  ID_W            index of the requester owning the response
//  busy        out  1               high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - state=IDLE, and all outputs are 0.
//  - Operand, op and result registers clear to 0.
//  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has top priority first.
//  FSM IDLE -> EXEC -> RESP -> IDLE:
//  - IDLE: g = the first i with req_valid[i]=1, searching from last_grant+1 upward with wrap.
//    - req_ready[g]=1 combinationally; all other req_ready bits are 0.
//    - No valid request: req_ready=0 and the FSM stays in IDLE.
//    - On accept, latch req_a/req_b/req_op slice g into op regs, set rsp_id=g,
//      set last_grant=g, and go to EXEC.
//  - EXEC (exactly 1 cycle): ALU inputs are stable from the op regs.
//    - At the clock edge, capture alu_result into rsp_result and alu_zero into rsp_zero.
//    - Go to RESP.
//  - RESP: rsp_valid[rsp_id]=1 and all other rsp_valid bits are 0.
//    - rsp_result, rsp_zero and rsp_id are held stable until the handshake completes.
//    - When rsp_ready[rsp_id]=1, go to IDLE. rsp_ready bits of other requesters are ignored.
//  - req_ready is 0 in EXEC and RESP, so there is only ever one transaction in flight.
//  Outputs and timing:
//  - alu_a, alu_b and alu_ctrl always equal the op regs.
//    They hold their last values outside EXEC and are 0 after reset.
//  - Latency: accept at edge T; rsp_valid is high from T+2. Best-case throughput is
//    1 transaction per 3 cycles.
//  Boundary conditions:
//  - Multiple simultaneous valids: only g is accepted. The others must keep req_valid high
//    and are served in rotating order, so no requester starves.
//  - req_valid dropped before accept: the request is not served and leaves no state behind.
//  - rsp_ready held low: stay in RESP indefinitely with no timeout.
//  - Reset mid-EXEC/RESP: the transaction is discarded with no response, and rsp_valid
//    drops asynchronously.
//  - No widening or truncation: data widths are DATA_W end-to-end.
// TESTING
//  1. Reset with req_valid=4'b1111 -> order of grants over 4 transactions is 0,1,2,3;
//     each rsp_id matches its grant.
//  2. Single req 2: A=4'h5, B=4'h3, ALU model returns 4'h1 -> req_ready[2] at T,
//     rsp_valid=4'b0100, rsp_result=4'h1, rsp_zero=0, at T+2.
//  3. Result 4'h0 with rsp_ready held low 5 cycles -> rsp_valid, rsp_zero=1 and rsp_result
//     stable throughout; busy=1; no req_ready during RESP.
//  4. req 1 and req 3 continuously valid, last_grant=1 -> grants alternate 3,1,3,1;
//     neither requester starves.
//  5. rst_n pulsed low in EXEC -> rsp_valid=0, busy=0 and alu_* = 0 immediately;
//     next grant goes to req 0.
//  6. rsp_ready asserted on the wrong requester in RESP -> no state change;
//     correct rsp_ready -> IDLE next cycle.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one external combinational ALU between NUM_REQ requesters.
// One transaction is in flight at a time: accept (IDLE), drive ALU (EXEC), hold the response (RESP).
module alu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int OP_W    = 3,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_ctrl,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;

  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;

  // Search starts just past the last winner and wraps, so every waiting requester gets a turn.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    sel_a       = '0;
    sel_b       = '0;
    sel_op      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
        sel_a       = req_a[idx*DATA_W +: DATA_W];
        sel_b       = req_b[idx*DATA_W +: DATA_W];
        sel_op      = req_op[idx*OP_W +: OP_W];
      end
    end
  end

  // Gated by rst_n so nothing is offered while reset is asserted.
  assign req_ready = (rst_n && state == IDLE && grant_found) ?
                     (NUM_REQ'(1) << grant_id) : '0;

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            a_q        <= sel_a;
            b_q        <= sel_b;
            op_q       <= sel_op;
            rsp_id     <= grant_id;
            last_grant <= grant_id;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= NUM_REQ'(1) << rsp_id;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready[rsp_id]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: a directed vector table, hand sequences for the multi-cycle corners,
// and a randomized phase checked against a simple round-robin/ALU reference model.
module tb_alu_rr_arbiter;

  localparam int NR = 4;
  localparam int DW = 4;
  localparam int OW = 3;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a;
  logic [NR*DW-1:0]  req_b;
  logic [NR*OW-1:0]  req_op;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic [OW-1:0]     alu_ctrl;
  logic [DW-1:0]     alu_result;
  logic              alu_zero;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [DW-1:0]     rsp_result;
  logic              rsp_zero;
  logic [1:0]        rsp_id;
  logic              busy;

  int n_cmp;
  int n_fail;
  int m_last;

  alu_rr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_id(rsp_id),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external 4-bit ALU.
  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [OW-1:0] op);
    case (op)
      3'd0:    alu_fn = a + b;
      3'd1:    alu_fn = a - b;
      3'd2:    alu_fn = a & b;
      3'd3:    alu_fn = a | b;
      3'd4:    alu_fn = a ^ b;
      3'd5:    alu_fn = ~a;
      3'd6:    alu_fn = {a[DW-2:0], 1'b0};
      default: alu_fn = (a < b) ? 4'd1 : 4'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_result == '0);

  function automatic int model_grant(input logic [NR-1:0] mask, input int last);
    model_grant = -1;
    for (int k = 1; k <= NR; k++) begin
      if (model_grant < 0 && mask[(last + k) % NR]) model_grant = (last + k) % NR;
    end
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full transaction; hold = cycles the owner keeps rsp_ready low while others poke theirs.
  task automatic apply_stimulus(input logic [NR-1:0] valid, input logic [NR*DW-1:0] a,
                                input logic [NR*DW-1:0] b, input logic [NR*OW-1:0] op,
                                input int g, input int hold);
    logic [DW-1:0] ea, eb, er;
    logic [OW-1:0] eo;
    logic [NR-1:0] onehot;
    ea = a[g*DW +: DW];
    eb = b[g*DW +: DW];
    eo = op[g*OW +: OW];
    er = alu_fn(ea, eb, eo);
    onehot = NR'(1) << g;
    @(negedge clk);
    req_valid = valid; req_a = a; req_b = b; req_op = op; rsp_ready = '0;
    #1;
    check_output("grant_ready", 32'(req_ready), 32'(onehot));
    check_output("idle_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    req_valid = '0; req_a = NR*DW'($urandom); req_b = NR*DW'($urandom); req_op = NR*OW'($urandom);
    @(negedge clk);
    check_output("exec_busy", 32'(busy), 1);
    check_output("exec_ready", 32'(req_ready), 0);
    check_output("exec_rsp_valid", 32'(rsp_valid), 0);
    check_output("exec_alu_a", 32'(alu_a), 32'(ea));
    check_output("exec_alu_b", 32'(alu_b), 32'(eb));
    check_output("exec_alu_ctrl", 32'(alu_ctrl), 32'(eo));
    @(negedge clk);
    check_output("rsp_valid", 32'(rsp_valid), 32'(onehot));
    check_output("rsp_id", 32'(rsp_id), 32'(g));
    check_output("rsp_result", 32'(rsp_result), 32'(er));
    check_output("rsp_zero", 32'(rsp_zero), 32'(er == 0));
    for (int i = 0; i < hold; i++) begin
      rsp_ready = ~onehot & NR'($urandom);
      req_valid = '1;
      @(negedge clk);
      check_output("hold_rsp_valid", 32'(rsp_valid), 32'(onehot));
      check_output("hold_result", 32'(rsp_result), 32'(er));
      check_output("hold_zero", 32'(rsp_zero), 32'(er == 0));
      check_output("hold_id", 32'(rsp_id), 32'(g));
      check_output("hold_busy", 32'(busy), 1);
      check_output("hold_ready", 32'(req_ready), 0);
    end
    rsp_ready = onehot;
    @(posedge clk);
    #1;
    rsp_ready = '0;
    req_valid = '0;
    check_output("done_busy", 32'(busy), 0);
    check_output("done_rsp_valid", 32'(rsp_valid), 0);
    m_last = g;
  endtask

  typedef struct {
    logic [NR-1:0]    valid;
    logic [NR*DW-1:0] a;
    logic [NR*DW-1:0] b;
    logic [NR*OW-1:0] op;
    int               grant;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [NR-1:0] mask;
    int g;
    n_cmp = 0; n_fail = 0; m_last = NR - 1;

    // After reset the grant order is 0,1,2,3; then a lone req 2 doing 5 AND 3 = 1;
    // then reqs 1 and 3 alternate.
    vecs[0]  = '{4'b1111, 16'h4321, 16'h1111, 12'o0000, 0};
    vecs[1]  = '{4'b1111, 16'h4321, 16'h1111, 12'o1111, 1};
    vecs[2]  = '{4'b1111, 16'h9abc, 16'h3456, 12'o3333, 2};
    vecs[3]  = '{4'b1111, 16'h7e5d, 16'h2222, 12'o4444, 3};
    vecs[4]  = '{4'b0100, 16'h0500, 16'h0300, 12'o0200, 2};
    vecs[5]  = '{4'b1010, 16'h60a0, 16'h3050, 12'o0000, 3};
    vecs[6]  = '{4'b1010, 16'h60a0, 16'h3050, 12'o0000, 1};
    vecs[7]  = '{4'b1010, 16'hc0f0, 16'h1020, 12'o1010, 3};
    vecs[8]  = '{4'b1010, 16'hc0f0, 16'h1020, 12'o1010, 1};
    vecs[9]  = '{4'b1010, 16'h8010, 16'h8010, 12'o1010, 3};
    vecs[10] = '{4'b1010, 16'h8010, 16'h8010, 12'o1010, 1};

    rst_n = 1'b0; req_valid = 4'b1111; req_a = 16'h1234; req_b = 16'h5678; req_op = 12'o1234;
    rsp_ready = '0;
    #1;
    check_output("reset_ready", 32'(req_ready), 0);
    check_output("reset_rsp_valid", 32'(rsp_valid), 0);
    check_output("reset_busy", 32'(busy), 0);
    check_output("reset_alu", 32'({alu_a, alu_b, alu_ctrl}), 0);
    check_output("reset_rsp", 32'({rsp_result, rsp_zero, rsp_id}), 0);
    repeat (3) @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      apply_stimulus(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].grant, 0);

    $display("[TB] zero result with response held off");
    apply_stimulus(4'b0100, 16'h0700, 16'h0700, 12'o0100, 2, 5);

    $display("[TB] request withdrawn before accept");
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    check_output("withdraw_ready", 32'(req_ready), 32'(4'b1000));
    #2;
    req_valid = '0;
    @(posedge clk);
    #1;
    check_output("withdraw_busy", 32'(busy), 0);
    apply_stimulus(4'b1001, 16'h1234, 16'h4321, 12'o3210, model_grant(4'b1001, m_last), 1);

    $display("[TB] reset during EXEC");
    @(negedge clk);
    req_valid = 4'b0010; req_a = 16'h00f0; req_b = 16'h0050; req_op = 12'o0030;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check_output("rst_exec_busy", 32'(busy), 0);
    check_output("rst_exec_rsp_valid", 32'(rsp_valid), 0);
    check_output("rst_exec_alu", 32'({alu_a, alu_b, alu_ctrl}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = NR - 1;
    apply_stimulus(4'b1111, 16'h5555, 16'h3333, 12'o2222, 0, 0);

    $display("[TB] reset during RESP");
    @(negedge clk);
    req_valid = 4'b0100; req_a = 16'h0a00; req_b = 16'h0600; req_op = 12'o0000;
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check_output("pre_rst_rsp_valid", 32'(rsp_valid), 32'(4'b0100));
    rst_n = 1'b0;
    #1;
    check_output("rst_resp_rsp_valid", 32'(rsp_valid), 0);
    check_output("rst_resp_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = NR - 1;

    $display("[TB] randomized traffic");
    for (int it = 0; it < 60; it++) begin
      mask = NR'($urandom_range(0, 15));
      if (mask == '0) begin
        @(negedge clk);
        req_valid = '0;
        #1;
        check_output("idle_no_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        check_output("idle_stays", 32'(busy), 0);
      end else begin
        g = model_grant(mask, m_last);
        apply_stimulus(mask, NR*DW'($urandom), NR*DW'($urandom), NR*OW'($urandom), g,
                       $urandom_range(0, 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
